random_delay_gen: RTL and testbench

RANDOM_DELAY_GEN -- requirements
Module: random_delay_gen

---
 rtl/random_delay_gen.sv | 124 ++++++++++++
 tb/tb_random_delay_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/random_delay_gen.sv
// Randomised reaction-timer delay: draws a delay from an LFSR, counts it out in ticks,
// and reports the expiry or a premature user response.
module random_delay_gen #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned TICK_HZ   = 1000,
    parameter int unsigned WIDTH     = 14,
    parameter int unsigned MIN_DELAY = 1000,
    parameter int unsigned MAX_DELAY = 9999,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic             response,
    input  logic             repeat_mode,
    output logic             delay_pulse,
    output logic             false_start,
    output logic             busy,
    output logic [WIDTH-1:0] delay_value,
    output logic [WIDTH-1:0] elapsed
);

    localparam int unsigned SPAN = MAX_DELAY - MIN_DELAY + 1;
    localparam int unsigned KW   = (SPAN > 1) ? $clog2(SPAN) : 1;
    localparam int unsigned DIV  = (TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 1;
    localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;

    if (!(TICK_HZ > 0 && MIN_DELAY >= 1 && MAX_DELAY >= MIN_DELAY &&
          64'(MAX_DELAY) < (64'd1 << WIDTH) && SPAN <= 65536 &&
          (CLK_HZ % TICK_HZ) == 0 && LFSR_SEED != 16'h0000)) begin : g_param_check
        $error("random_delay_gen: invalid parameter set");
    end

    typedef enum logic [1:0] {StIdle, StDraw, StWait, StFire} state_e;

    state_e           state_q;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_next;
    logic [PW-1:0]    presc_q;
    logic [KW-1:0]    sample;
    logic             draw_ok;
    logic [WIDTH-1:0] draw_val;
    logic             tick;
    logic [WIDTH-1:0] elapsed_inc;

    // Galois form of x^16+x^14+x^13+x^11+1 (right shift, tap mask 0xB400)
    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & 16'hB400);

    // Rejection sampling keeps the draw uniform over MIN_DELAY..MAX_DELAY
    assign sample   = lfsr_q[KW-1:0];
    assign draw_ok  = (SPAN == 1) || (32'(sample) < SPAN);
    assign draw_val = (SPAN == 1) ? WIDTH'(MIN_DELAY) : WIDTH'(MIN_DELAY + 32'(sample));

    assign tick        = (presc_q == PW'(DIV - 1));
    assign elapsed_inc = elapsed + WIDTH'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            lfsr_q      <= LFSR_SEED;
            presc_q     <= '0;
            elapsed     <= '0;
            delay_value <= '0;
            delay_pulse <= 1'b0;
            false_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_next;
            delay_pulse <= 1'b0;
            false_start <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!cancel && start) begin
                        state_q <= StDraw;
                        busy    <= 1'b1;
                        elapsed <= '0;
                    end
                end
                StDraw, StWait: begin
                    if (cancel) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else if (response) begin
                        state_q     <= StIdle;
                        busy        <= 1'b0;
                        false_start <= 1'b1;
                    end else if (start) begin
                        state_q <= StDraw;
                        elapsed <= '0;
                    end else if (state_q == StDraw) begin
                        if (draw_ok) begin
                            state_q     <= StWait;
                            delay_value <= draw_val;
                            elapsed     <= '0;
                            presc_q     <= '0;
                        end
                    end else if (tick) begin
                        presc_q <= '0;
                        elapsed <= elapsed_inc;
                        if (elapsed_inc == delay_value) begin
                            state_q     <= StFire;
                            busy        <= 1'b0;
                            delay_pulse <= 1'b1;
                        end
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                StFire: begin
                    if (!cancel && repeat_mode) begin
                        state_q <= StDraw;
                        busy    <= 1'b1;
                        elapsed <= '0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_random_delay_gen.sv
// Directed bench for random_delay_gen with a reference LFSR to predict each draw.
module tb_random_delay_gen;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         cancel = 1'b0;
    logic         response = 1'b0;
    logic         repeat_mode = 1'b0;
    logic         delay_pulse;
    logic         false_start;
    logic         busy;
    logic [W-1:0] delay_value;
    logic [W-1:0] elapsed;

    int errors = 0;
    int checks = 0;

    random_delay_gen #(
        .CLK_HZ   (10),
        .TICK_HZ  (1),
        .WIDTH    (W),
        .MIN_DELAY(3),
        .MAX_DELAY(5),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cancel     (cancel),
        .response   (response),
        .repeat_mode(repeat_mode),
        .delay_pulse(delay_pulse),
        .false_start(false_start),
        .busy       (busy),
        .delay_value(delay_value),
        .elapsed    (elapsed)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] s;
        s = {1'b0, v[15:1]};
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    // Reference LFSR running in lockstep with the DUT's free-running one
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 16'hACE1;
        else      m_lfsr <= lfsr_step(m_lfsr);
    end

    typedef struct {
        int   pre;
        logic c;
        logic r;
        logic s;
        logic exp_busy;
        logic exp_fs;
        int   exp_el;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called in the first DRAW cycle; returns once the DUT is in its first WAIT cycle.
    task automatic draw_to_wait(input string tag, output int d);
        logic [15:0] l;
        int n;
        l = m_lfsr;
        n = 0;
        while (l[1:0] == 2'd3 && n < 100) begin
            l = lfsr_step(l);
            n++;
        end
        d = 3 + int'(l[1:0]);
        repeat (n + 1) step();
        chk({tag, "_delay_value"}, int'(delay_value), d);
        chk({tag, "_elapsed_clr"}, int'(elapsed), 0);
        chk({tag, "_busy_wait"}, int'(busy), 1);
    endtask

    task automatic arm(input string tag, output int d);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy_rise"}, int'(busy), 1);
        draw_to_wait(tag, d);
    endtask

    // Called in the first WAIT cycle; returns in the FIRE cycle.
    task automatic wait_fire(input string tag, input int d);
        int p;
        p = 0;
        while (!delay_pulse && p < 200) begin
            step();
            p++;
        end
        chk({tag, "_fire_time"}, p, d * 10);
        chk({tag, "_elapsed_fire"}, int'(elapsed), d);
        chk({tag, "_busy_fire"}, int'(busy), 0);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            if (delay_pulse) seen++;
            step();
        end
        chk({tag, "_no_pulse"}, seen, 0);
    endtask

    initial begin
        int d;
        int d2;
        int first_d;

        //        pre  c     r     s     busy  fs    elapsed
        vecs[0] = '{15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vecs[1] = '{5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[2] = '{12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1};
        vecs[3] = '{20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[4] = '{25, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        vecs[5] = '{28, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2};

        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_pulse", int'(delay_pulse), 0);
        chk("rst_fs", int'(false_start), 0);
        chk("rst_delay", int'(delay_value), 0);
        chk("rst_elapsed", int'(elapsed), 0);
        repeat (3) step();
        rst = 1'b1;

        // Power-up draw; its value is reused after the mid-WAIT reset below.
        repeat (4) step();
        arm("first", d);
        first_d = d;
        wait_fire("first", d);
        step();
        chk("first_pulse_width", int'(delay_pulse), 0);
        chk("first_idle_busy", int'(busy), 0);
        expect_quiet("first_idle", 20);

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            arm(tag, d);
            repeat (vecs[i].pre) step();
            cancel   = vecs[i].c;
            response = vecs[i].r;
            start    = vecs[i].s;
            step();
            cancel   = 1'b0;
            response = 1'b0;
            start    = 1'b0;
            chk({tag, "_busy"}, int'(busy), int'(vecs[i].exp_busy));
            chk({tag, "_false_start"}, int'(false_start), int'(vecs[i].exp_fs));
            chk({tag, "_elapsed"}, int'(elapsed), vecs[i].exp_el);
            chk({tag, "_pulse"}, int'(delay_pulse), 0);
            if (vecs[i].exp_busy) begin
                draw_to_wait({tag, "_re"}, d2);
                wait_fire({tag, "_re"}, d2);
                step();
                chk({tag, "_re_idle"}, int'(busy), 0);
            end else begin
                step();
                chk({tag, "_fs_width"}, int'(false_start), 0);
                expect_quiet(tag, 60);
            end
        end

        // Repeat mode: three back-to-back fires, then cancel.
        repeat_mode = 1'b1;
        arm("rep", d);
        for (int k = 0; k < 3; k++) begin
            string tag;
            tag = $sformatf("rep%0d", k);
            wait_fire(tag, d);
            step();
            chk({tag, "_redraw_busy"}, int'(busy), 1);
            draw_to_wait(tag, d);
        end
        repeat (5) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        repeat_mode = 1'b0;
        chk("rep_cancel_busy", int'(busy), 0);
        chk("rep_cancel_fs", int'(false_start), 0);
        expect_quiet("rep_cancel", 80);

        // Reset pulse mid-WAIT: outputs clear without a clock edge.
        arm("mid", d);
        repeat (12) step();
        rst = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_pulse", int'(delay_pulse), 0);
        chk("midrst_fs", int'(false_start), 0);
        chk("midrst_delay", int'(delay_value), 0);
        chk("midrst_elapsed", int'(elapsed), 0);
        step();
        rst = 1'b1;
        repeat (4) step();
        arm("after", d);
        chk("after_same_draw", d, first_d);
        wait_fire("after", d);
        step();
        chk("after_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
